// File: rtl/meas_rd_latency_hist.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | meas_rd_latency_hist                                                       |
// | In-order Avalon-MM read latency tracker with min/max/sum/count/histogram.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module meas_rd_latency_hist #(
    parameter int AMM_BURST_W = 11,
    parameter int OUTSTANDING = 4,
    parameter int DELAY_W     = 16,
    parameter int HIST_BINS   = 8,
    parameter int BIN_SHIFT   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             read_i,
    input  logic                             waitrequest_i,
    input  logic [AMM_BURST_W-1:0]           burstcount_i,
    input  logic                             readdatavalid_i,
    input  logic                             test_start_i,
    output logic                             meas_busy_o,
    output logic [$clog2(OUTSTANDING):0]     outstanding_o,
    output logic [DELAY_W-1:0]               min_delay_o,
    output logic [DELAY_W-1:0]               max_delay_o,
    output logic [31:0]                      sum_delay_o,
    output logic [31:0]                      meas_cnt_o,
    output logic [HIST_BINS*32-1:0]          hist_o,
    output logic                             overflow_o,
    output logic                             orphan_o
);

    localparam int c_ptr_w = $clog2(OUTSTANDING);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_bin_w = $clog2(HIST_BINS);

    logic [AMM_BURST_W-1:0] r_words   [OUTSTANDING];
    logic                   r_pending [OUTSTANDING];
    logic [DELAY_W-1:0]     r_delay   [OUTSTANDING];
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_cnt_w-1:0]     r_count;

    logic                   r_s1_valid;
    logic [DELAY_W-1:0]     r_s1_lat;
    logic                   r_s2_valid;
    logic [DELAY_W-1:0]     r_min;
    logic [DELAY_W-1:0]     r_max;
    logic [31:0]            r_sum;
    logic [31:0]            r_cnt;
    logic [31:0]            r_hist [HIST_BINS];
    logic                   r_overflow;
    logic                   r_orphan;

    logic                   w_accept;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_rdv_hit;
    logic                   w_last;
    logic                   w_push;
    logic                   w_first;
    logic [DELAY_W-1:0]     w_head_delay;
    logic [DELAY_W-1:0]     w_lat;
    logic [DELAY_W-1:0]     w_shifted;
    logic [c_bin_w-1:0]     w_bin;
    logic [32:0]            w_sum_nxt;

    assign w_accept     = read_i && !waitrequest_i;
    assign w_full       = (r_count == c_cnt_w'(OUTSTANDING));
    assign w_empty      = (r_count == '0);
    assign w_rdv_hit    = readdatavalid_i && !w_empty;
    assign w_last       = w_rdv_hit && (r_words[r_rptr] == AMM_BURST_W'(1));
    // A full tracker that retires its head this cycle still has room for the new burst
    assign w_push       = w_accept && (!w_full || w_last);
    assign w_first      = w_rdv_hit && r_pending[r_rptr];
    assign w_head_delay = r_delay[r_rptr];
    // The stored delay lags the cycle count by one, so latency is delay+1 (saturated)
    assign w_lat        = (w_head_delay == '1) ? w_head_delay : w_head_delay + DELAY_W'(1);

    for (genvar i = 0; i < OUTSTANDING; i++) begin : g_slot
        logic w_wsel;
        logic w_rsel;
        assign w_wsel = (r_wptr == c_ptr_w'(i));
        assign w_rsel = (r_rptr == c_ptr_w'(i));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_words[i]   <= '0;
                r_pending[i] <= 1'b0;
                r_delay[i]   <= '0;
            end else if (w_push && w_wsel) begin
                r_words[i]   <= (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
                r_pending[i] <= 1'b1;
                r_delay[i]   <= '0;
            end else begin
                if (r_pending[i] && (r_delay[i] != '1)) begin
                    r_delay[i] <= r_delay[i] + DELAY_W'(1);
                end
                if (w_rdv_hit && w_rsel) begin
                    r_words[i]   <= r_words[i] - AMM_BURST_W'(1);
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_last) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            unique case ({w_push, w_last})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_shifted = r_s1_lat >> BIN_SHIFT;
    assign w_bin     = (w_shifted > DELAY_W'(HIST_BINS - 1)) ? c_bin_w'(HIST_BINS - 1)
                                                             : w_shifted[c_bin_w-1:0];
    assign w_sum_nxt = {1'b0, r_sum} + {{(33 - DELAY_W){1'b0}}, r_s1_lat};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_lat   <= '0;
            r_s2_valid <= 1'b0;
            r_min      <= '1;
            r_max      <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            r_s1_valid <= w_first && !test_start_i;
            r_s1_lat   <= w_lat;
            if (test_start_i) begin
                r_s2_valid <= 1'b0;
                r_min      <= '1;
                r_max      <= '0;
                r_sum      <= '0;
                r_cnt      <= '0;
                r_overflow <= 1'b0;
                r_orphan   <= 1'b0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    if (r_s1_lat < r_min) begin
                        r_min <= r_s1_lat;
                    end
                    if (r_s1_lat > r_max) begin
                        r_max <= r_s1_lat;
                    end
                    r_sum <= w_sum_nxt[32] ? 32'hFFFF_FFFF : w_sum_nxt[31:0];
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                if (w_accept && w_full && !w_last) begin
                    r_overflow <= 1'b1;
                end
                if (readdatavalid_i && w_empty) begin
                    r_orphan <= 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < HIST_BINS; b++) begin : g_hist
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_hist[b] <= '0;
            end else if (test_start_i) begin
                r_hist[b] <= '0;
            end else if (r_s1_valid && (w_bin == c_bin_w'(b)) && (r_hist[b] != '1)) begin
                r_hist[b] <= r_hist[b] + 32'd1;
            end
        end
        assign hist_o[b*32 +: 32] = r_hist[b];
    end

    assign meas_busy_o   = !w_empty || r_s1_valid || r_s2_valid;
    assign outstanding_o = r_count;
    assign min_delay_o   = r_min;
    assign max_delay_o   = r_max;
    assign sum_delay_o   = r_sum;
    assign meas_cnt_o    = r_cnt;
    assign overflow_o    = r_overflow;
    assign orphan_o      = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_meas_rd_latency_hist.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_meas_rd_latency_hist                                                    |
// | Bench for meas_rd_latency_hist (default and DELAY_W=4 instances).          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_meas_rd_latency_hist;

    localparam int OUT = 4;
    localparam int HB  = 8;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, wr, rdv, ts;
    logic [10:0] bc;

    logic        d1_busy, d1_ovf, d1_orph;
    logic [2:0]  d1_outs;
    logic [15:0] d1_min, d1_max;
    logic [31:0] d1_sum, d1_cnt;
    logic [255:0] d1_hist;

    logic        d2_busy, d2_ovf, d2_orph;
    logic [2:0]  d2_outs;
    logic [3:0]  d2_min, d2_max;
    logic [31:0] d2_sum, d2_cnt;
    logic [255:0] d2_hist;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    meas_rd_latency_hist dut (
        .clk_i(clk), .rst_i(rst), .read_i(read), .waitrequest_i(wr),
        .burstcount_i(bc), .readdatavalid_i(rdv), .test_start_i(ts),
        .meas_busy_o(d1_busy), .outstanding_o(d1_outs), .min_delay_o(d1_min),
        .max_delay_o(d1_max), .sum_delay_o(d1_sum), .meas_cnt_o(d1_cnt),
        .hist_o(d1_hist), .overflow_o(d1_ovf), .orphan_o(d1_orph)
    );

    meas_rd_latency_hist #(.DELAY_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .read_i(read), .waitrequest_i(wr),
        .burstcount_i(bc), .readdatavalid_i(rdv), .test_start_i(ts),
        .meas_busy_o(d2_busy), .outstanding_o(d2_outs), .min_delay_o(d2_min),
        .max_delay_o(d2_max), .sum_delay_o(d2_sum), .meas_cnt_o(d2_cnt),
        .hist_o(d2_hist), .overflow_o(d2_ovf), .orphan_o(d2_orph)
    );

    // Reference model: a queue of in-flight bursts and a list of timestamped latency events
    typedef struct { int acc; int words; bit meas; } burst_t;
    typedef struct { int c; int lat; } ev_t;
    burst_t mq[$];
    ev_t    mev[$];
    int     cur;
    longint m_min, m_max, m_sum, m_cnt, m_hist[HB];
    longint m_min4, m_max4, m_sum4, m_hist4[HB];
    bit     m_ovf, m_orph, m_busy;

    task automatic model_clear();
        m_min = 65535; m_max = 0; m_sum = 0; m_cnt = 0;
        m_min4 = 15; m_max4 = 0; m_sum4 = 0;
        for (int b = 0; b < HB; b++) begin
            m_hist[b] = 0; m_hist4[b] = 0;
        end
        m_ovf = 0; m_orph = 0;
    endtask

    task automatic model_reset();
        mq.delete(); mev.delete(); cur = 0; m_busy = 0;
        model_clear();
    endtask

    task automatic model_apply(input int lat);
        longint l16, l4, b16, b4;
        l16 = (lat > 65535) ? 65535 : lat;
        l4  = (lat > 15) ? 15 : lat;
        if (l16 < m_min) m_min = l16;
        if (l16 > m_max) m_max = l16;
        if (l4 < m_min4) m_min4 = l4;
        if (l4 > m_max4) m_max4 = l4;
        m_sum  = (m_sum + l16 > MAX32) ? MAX32 : m_sum + l16;
        m_sum4 = (m_sum4 + l4 > MAX32) ? MAX32 : m_sum4 + l4;
        if (m_cnt < MAX32) m_cnt++;
        b16 = l16 / 4; if (b16 > HB - 1) b16 = HB - 1;
        b4  = l4 / 4;  if (b4 > HB - 1) b4 = HB - 1;
        if (m_hist[b16] < MAX32) m_hist[b16]++;
        if (m_hist4[b4] < MAX32) m_hist4[b4]++;
    endtask

    task automatic model_step(input bit r, input bit w, input int b, input bit d, input bit t);
        burst_t h;
        ev_t    tmp[$];
        if (d) begin
            if (mq.size() == 0) m_orph = 1;
            else begin
                h = mq[0];
                if (!h.meas) begin
                    h.meas = 1;
                    mev.push_back('{cur, cur - h.acc});
                end
                h.words--;
                if (h.words == 0) mq.delete(0);
                else mq[0] = h;
            end
        end
        if (r && !w) begin
            if (mq.size() < OUT) mq.push_back('{cur, (b == 0) ? 1 : b, 1'b0});
            else m_ovf = 1;
        end
        if (t) begin
            model_clear();
            mev.delete();
        end else begin
            foreach (mev[i]) if (mev[i].c == cur - 1) model_apply(mev[i].lat);
        end
        m_busy = (mq.size() != 0);
        foreach (mev[i]) if (mev[i].c >= cur - 1) m_busy = 1;
        tmp = mev; mev.delete();
        foreach (tmp[i]) if (tmp[i].c >= cur) mev.push_back(tmp[i]);
        cur++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check_model();
        chk("outstanding", d1_outs, mq.size());
        chk("overflow", d1_ovf, m_ovf);
        chk("orphan", d1_orph, m_orph);
        chk("busy", d1_busy, m_busy);
        chk("min", d1_min, m_min);
        chk("max", d1_max, m_max);
        chk("sum", d1_sum, m_sum);
        chk("cnt", d1_cnt, m_cnt);
        for (int b = 0; b < HB; b++) chk($sformatf("hist%0d", b), d1_hist[b*32 +: 32], m_hist[b]);
        chk("w4 outstanding", d2_outs, mq.size());
        chk("w4 busy", d2_busy, m_busy);
        chk("w4 min", d2_min, m_min4);
        chk("w4 max", d2_max, m_max4);
        chk("w4 sum", d2_sum, m_sum4);
        chk("w4 cnt", d2_cnt, m_cnt);
        for (int b = 0; b < HB; b++) chk($sformatf("w4 hist%0d", b), d2_hist[b*32 +: 32], m_hist4[b]);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic tick(input bit r, input bit w, input int b, input bit d, input bit t);
        read = r; wr = w; bc = 11'(b); rdv = d; ts = t;
        model_step(r, w, b, d, t);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    function automatic bit in_seq_b(input int k);
        return k == 3 || k == 4 || k == 8 || k == 9 || k == 14 || k == 15 || k == 43 || k == 44;
    endfunction

    typedef struct { bit rd; bit rdv; bit ts; int outs; bit ovf; bit orph; bit busy; } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{1, 0, 0, 2, 0, 0, 1};
        tbl[2]  = '{1, 0, 0, 3, 0, 0, 1};
        tbl[3]  = '{1, 0, 0, 4, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 4, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 4, 0, 0, 1};
        tbl[6]  = '{1, 1, 0, 4, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 3, 0, 0, 1};
        tbl[8]  = '{0, 1, 0, 2, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 1, 0, 0, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 0};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 0};

        rst = 1; read = 0; wr = 0; bc = '0; rdv = 0; ts = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset outstanding", d1_outs, 0);
        chk("reset min", d1_min, 16'hFFFF);
        chk("reset busy", d1_busy, 0);
        chk("reset cnt", d1_cnt, 0);
        check_model();
        rst = 0;

        // Fill, overflow, clear, simultaneous accept+retire on full, drain, orphan
        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].rd, 0, 1, tbl[i].rdv, tbl[i].ts);
            chk($sformatf("tbl%0d outstanding", i), d1_outs, tbl[i].outs);
            chk($sformatf("tbl%0d overflow", i), d1_ovf, tbl[i].ovf);
            chk($sformatf("tbl%0d orphan", i), d1_orph, tbl[i].orph);
            chk($sformatf("tbl%0d busy", i), d1_busy, tbl[i].busy);
            check_model();
        end
        chk("after clear min", d1_min, 16'hFFFF);

        // Single burst of 4, latency 5
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 4, 0, 0);
        idle(4);
        for (int k = 5; k <= 8; k++) begin
            tick(0, 0, 0, 1, 0);
            if (k == 7) chk("A outstanding t0+8", d1_outs, 1);
        end
        chk("A outstanding t0+9", d1_outs, 0);
        idle(2);
        chk("A busy t0+11", d1_busy, 0);
        chk("A min", d1_min, 5);
        chk("A max", d1_max, 5);
        chk("A sum", d1_sum, 5);
        chk("A cnt", d1_cnt, 1);
        chk("A hist1", d1_hist[32 +: 32], 1);
        check_model();

        // Four back-to-back bursts with latencies 3, 7, 12, 40
        tick(0, 0, 0, 0, 1);
        for (int k = 0; k <= 44; k++) tick(k < 4, 0, 2, in_seq_b(k), 0);
        idle(2);
        chk("B min", d1_min, 3);
        chk("B max", d1_max, 40);
        chk("B sum", d1_sum, 62);
        chk("B cnt", d1_cnt, 4);
        chk("B hist0", d1_hist[0 +: 32], 1);
        chk("B hist1", d1_hist[32 +: 32], 1);
        chk("B hist3", d1_hist[96 +: 32], 1);
        chk("B hist7", d1_hist[224 +: 32], 1);
        chk("B w4 max", d2_max, 15);
        check_model();

        // Latency 20 saturates in the 4-bit instance
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 1, 0, 0);
        idle(19);
        tick(0, 0, 0, 1, 0);
        idle(2);
        chk("sat w4 max", d2_max, 15);
        chk("sat w4 min", d2_min, 15);
        chk("sat max", d1_max, 20);
        check_model();

        // Clear colliding with a stage-2 update, then a burst spanning a clear
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 1, 0, 0);
        idle(1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        chk("C cnt", d1_cnt, 0);
        chk("C sum", d1_sum, 0);
        chk("C max", d1_max, 0);
        chk("C min", d1_min, 16'hFFFF);
        chk("C hist", d1_hist, 0);
        chk("C busy", d1_busy, 0);
        tick(1, 0, 2, 0, 0);
        idle(1);
        tick(0, 0, 0, 0, 1);
        idle(1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        idle(2);
        chk("C2 cnt", d1_cnt, 1);
        chk("C2 min", d1_min, 4);
        chk("C2 max", d1_max, 4);
        check_model();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit r, w, d, t;
            r = ($urandom % 3) == 0;
            w = ($urandom % 4) == 0;
            d = (mq.size() != 0) ? ($urandom % 2) == 1 : ($urandom % 16) == 0;
            t = ($urandom % 300) == 0;
            tick(r, w, int'($urandom % 4), d, t);
            check_model();
        end

        // Asynchronous reset mid-burst, then a stray readdatavalid
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 3, 0, 0);
        idle(1);
        tick(0, 0, 0, 1, 0);
        #2 rst = 1;
        #1;
        model_reset();
        chk("rst outstanding", d1_outs, 0);
        chk("rst min", d1_min, 16'hFFFF);
        chk("rst busy", d1_busy, 0);
        @(posedge clk); #1;
        rst = 0;
        tick(0, 0, 0, 1, 0);
        chk("rst orphan", d1_orph, 1);
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
